// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the fetch slice.
//   XLEN          - datapath / address width
//   INSTR_NOP     - word presented on out_instr while no instruction is valid
//   PC_STEP       - byte increment between sequential instruction words
//   fetch_state_t - fetch control states
//   pc_next()     - sequential successor of a PC (wraps mod 2^XLEN)
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // EMPTY : nothing in flight, current cycle only issues an address
  // STREAM: memory data for req_pc is on the read port
  // HOLD  : a stalled word sits in the capture buffer
  // FAULT : misaligned redirect seen; only reset leaves this state
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    STREAM = 2'd1,
    HOLD   = 2'd2,
    FAULT  = 2'd3
  } fetch_state_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: fetch -> decode valid/ready handshake.
//   valid - pc/instr carry an instruction
//   ready - decode accepts this cycle (transfer on valid & ready)
//   pc    - byte address of instr
//   instr - instruction word, NOP while valid is low
// Modports: master (fetch side), slave (decode side).
interface instruction_fetch_if;
  import riscv_pkg::*;

  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;

  modport master (output valid, output pc, output instr, input ready);
  modport slave  (input valid, input pc, input instr, output ready);

endinterface

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry capture buffer for a stalled instruction.
//   clk, resetn      - clock, asynchronous active-low reset
//   load             - capture data_in/pc_in and mark valid
//   clear            - drop the entry (wins over load)
//   data_in, pc_in   - word and its address to capture
//   data_q, pc_q     - captured word and address
//   vld_q            - entry holds an instruction
module fetch_hold_buf
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] data_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] data_q,
  output logic [XLEN-1:0] pc_q,
  output logic            vld_q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q <= '0;
      pc_q   <= '0;
      vld_q  <= 1'b0;
    end else if (clear) begin
      vld_q <= 1'b0;
    end else if (load) begin
      data_q <= data_in;
      pc_q   <= pc_in;
      vld_q  <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner and fetch control in front of a byte-addressed
// instruction memory with one-cycle registered read latency.
//   RESET_PC       - PC loaded on reset
//   clk, resetn    - clock, asynchronous active-low reset
//   imem_addr      - address issued this cycle (= pc_q)
//   imem_rdata     - data for the address issued last cycle
//   redirect_valid - load redirect_pc, flush everything in flight
//   redirect_pc    - redirect target
//   out            - {pc, instr} to decode over valid/ready (master side)
//   fault          - sticky misaligned-redirect flag
// Build option IFETCH_MISALIGN_CHECK_EN: when defined, a redirect with
// redirect_pc[1:0] != 0 parks the stage in FAULT until reset. When undefined,
// the low two bits of redirect_pc are ignored and fault is tied low.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       resetn,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [XLEN-1:0]            imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  instruction_fetch_if.master        out,
  output logic                       fault
);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            req_vld_q;
  logic [XLEN-1:0] hold_q;
  logic [XLEN-1:0] hold_pc_q;
  logic            hold_vld_q;

  logic [XLEN-1:0] redirect_tgt;
  logic            misalign;
  logic            in_fault;
  logic            stall;
  logic            hold_load;
  logic            hold_clear;
  logic [XLEN-1:0] src_pc;
  logic [XLEN-1:0] src_instr;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign redirect_tgt = redirect_pc;
  assign misalign     = (redirect_pc[1:0] != 2'b00);
  assign fault        = in_fault;
`else
  // Masking (rather than slicing) keeps every redirect_pc bit in use.
  assign redirect_tgt = redirect_pc & ~32'h0000_0003;
  assign misalign     = 1'b0;
  assign fault        = 1'b0;
`endif

  assign in_fault  = (state_q == FAULT);
  assign imem_addr = pc_q;

  // A redirect kills whatever is on the output in the same cycle.
  assign out.valid = (hold_vld_q | req_vld_q) & ~redirect_valid & ~in_fault;
  assign stall     = out.valid & ~out.ready;

  // Only the first stalled cycle of a streamed word needs capturing: the
  // memory output moves on next cycle, the buffer does not.
  assign hold_load  = ~in_fault & ~redirect_valid & stall & ~hold_vld_q;
  assign hold_clear = ~in_fault & (redirect_valid | ~stall);

  fetch_hold_buf u_hold (
    .clk     (clk),
    .resetn  (resetn),
    .load    (hold_load),
    .clear   (hold_clear),
    .data_in (imem_rdata),
    .pc_in   (req_pc_q),
    .data_q  (hold_q),
    .pc_q    (hold_pc_q),
    .vld_q   (hold_vld_q)
  );

  always_comb begin
    src_pc    = '0;
    src_instr = INSTR_NOP;
    case (state_q)
      HOLD: begin
        src_pc    = hold_pc_q;
        src_instr = hold_q;
      end
      STREAM: begin
        src_pc    = req_pc_q;
        src_instr = imem_rdata;
      end
      default: ;
    endcase
  end

  assign out.pc    = out.valid ? src_pc : '0;
  assign out.instr = out.valid ? src_instr : INSTR_NOP;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= EMPTY;
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      req_vld_q <= 1'b0;
    end else if (state_q != FAULT) begin
      if (redirect_valid) begin
        req_vld_q <= 1'b0;
        if (misalign) begin
          // pc_q stays frozen at its pre-redirect value.
          state_q <= FAULT;
        end else begin
          pc_q    <= redirect_tgt;
          state_q <= EMPTY;
        end
      end else if (!stall) begin
        pc_q      <= pc_next(pc_q);
        req_pc_q  <= pc_q;
        req_vld_q <= 1'b1;
        state_q   <= STREAM;
      end else if (state_q == STREAM) begin
        // The word now on the read port goes into the hold buffer; re-issue
        // pc_q so its data is back on the read port when the stall lifts.
        req_pc_q <= pc_q;
        state_q  <= HOLD;
      end
      // HOLD with stall: everything stays put.
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  import riscv_pkg::*;

`ifdef IFETCH_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;

  int checks = 0;
  int failures = 0;

  instruction_fetch_if ifc ();

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out            (ifc),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  // Memory image: word at byte address a is 32'hC0DE_0000 + a.
  always @(posedge clk) imem_rdata <= 32'hC0DE_0000 + imem_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic expect_out(input string tag, input bit v, input logic [31:0] pc, input logic [31:0] instr);
    check_eq({tag, ".valid"}, {31'd0, ifc.valid}, {31'd0, v});
    if (v) begin
      check_eq({tag, ".pc"}, ifc.pc, pc);
      check_eq({tag, ".instr"}, ifc.instr, instr);
    end else begin
      check_eq({tag, ".nop"}, ifc.instr, INSTR_NOP);
    end
  endtask

  task automatic expect_reset(input string tag);
    check_eq({tag, ".valid"}, {31'd0, ifc.valid}, 32'd0);
    check_eq({tag, ".instr"}, ifc.instr, INSTR_NOP);
    check_eq({tag, ".pc"}, ifc.pc, 32'd0);
    check_eq({tag, ".addr"}, imem_addr, 32'd0);
    check_eq({tag, ".fault"}, {31'd0, fault}, 32'd0);
  endtask

  // Advance one edge, apply inputs for the new cycle, settle to the negedge.
  task automatic cyc(input bit rdy, input bit rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    ifc.ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    ifc.ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    resetn         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_reset("reset");

    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    expect_out("empty", 1'b0, 32'd0, 32'd0);

    // Streaming at full rate.
    cyc(1, 0, 0);  expect_out("s0", 1, 32'h0, 32'hC0DE_0000);
    cyc(1, 0, 0);  expect_out("s4", 1, 32'h4, 32'hC0DE_0004);
    // Three stalled cycles on (8,w2), then accepted.
    cyc(0, 0, 0);  expect_out("st1", 1, 32'h8, 32'hC0DE_0008);
    cyc(0, 0, 0);  expect_out("st2", 1, 32'h8, 32'hC0DE_0008);
    cyc(0, 0, 0);  expect_out("st3", 1, 32'h8, 32'hC0DE_0008);
    cyc(1, 0, 0);  expect_out("rel", 1, 32'h8, 32'hC0DE_0008);
    cyc(1, 0, 0);  expect_out("s12", 1, 32'hC, 32'hC0DE_000C);

    // Redirect while streaming: current word dropped, target 2 cycles later.
    cyc(1, 1, 32'h40); expect_out("rd_kill", 0, 0, 0);
    cyc(1, 0, 0);      expect_out("rd_gap", 0, 0, 0);
    cyc(1, 0, 0);      expect_out("rd_t", 1, 32'h40, 32'hC0DE_0040);

    // Redirect during HOLD.
    cyc(0, 0, 0);      expect_out("h_st", 1, 32'h44, 32'hC0DE_0044);
    cyc(0, 0, 0);      expect_out("h_hold", 1, 32'h44, 32'hC0DE_0044);
    cyc(0, 1, 32'h80); expect_out("h_kill", 0, 0, 0);
    cyc(1, 0, 0);      expect_out("h_gap", 0, 0, 0);
    cyc(1, 0, 0);      expect_out("h_t", 1, 32'h80, 32'hC0DE_0080);

    // Misaligned redirect.
    cyc(1, 1, 32'h42); expect_out("m_kill", 0, 0, 0);
    cyc(1, 0, 0);      expect_out("m_gap", 0, 0, 0);
    check_eq("m_fault1", {31'd0, fault}, {31'd0, MIS});
    cyc(1, 0, 0);      expect_out("m_t", !MIS, 32'h40, 32'hC0DE_0040);
    check_eq("m_fault2", {31'd0, fault}, {31'd0, MIS});
    cyc(0, 0, 0);      expect_out("m_st", !MIS, 32'h44, 32'hC0DE_0044);
    cyc(0, 0, 0);      expect_out("m_hold", !MIS, 32'h44, 32'hC0DE_0044);

    // Asynchronous reset in the middle of a stall.
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 expect_reset("areset");
    @(posedge clk);
    #1 expect_reset("areset_hold");
    resetn    = 1'b1;
    ifc.ready = 1'b1;
    @(negedge clk);
    expect_out("r_empty", 0, 0, 0);
    cyc(1, 0, 0);  expect_out("r_s0", 1, 32'h0, 32'hC0DE_0000);
    cyc(1, 0, 0);  expect_out("r_s4", 1, 32'h4, 32'hC0DE_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
